// File: rtl/shared_sub_pkg.sv
// Shared types and defaults for the shared subtract scheduler.
// Holds the FSM state encoding, parameter defaults and the borrow helper.
package shared_sub_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    WAIT_ACK = 2'd2
  } sched_state_t;

  localparam int DEF_N         = 4;
  localparam int DEF_W         = 8;
  localparam int DEF_SUB_DELAY = 2;

  // Operands are zero-extended by the caller, so widths up to 32 bits are covered.
  function automatic logic sub_borrow(input logic [31:0] a, input logic [31:0] b);
    return (a < b);
  endfunction

endpackage

// File: rtl/shared_subtract_scheduler_if.sv
// Requester/consumer bundle of the shared subtract scheduler: N toggle req/ack
// channels with bundled operands in, one toggle result channel out.
interface shared_subtract_scheduler_if
  import shared_sub_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N-1:0]   ack;
  logic [N*W-1:0] a_data;
  logic [N*W-1:0] b_data;
  logic           out_req;
  logic           out_ack;
  logic [W-1:0]   out_diff;
  logic           out_borrow;
  logic [IDW-1:0] out_id;
  logic           busy;

  modport slave (
    input  req, a_data, b_data, out_ack,
    output ack, out_req, out_diff, out_borrow, out_id, busy
  );

  modport master (
    output req, a_data, b_data, out_ack,
    input  ack, out_req, out_diff, out_borrow, out_id, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating first-one search: grants the first pending channel at or after i_ptr.
// Purely combinational, no backpressure of its own.
module rr_pick
  import shared_sub_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   i_pending,
  input  logic [IDW-1:0] i_ptr,
  output logic           o_gnt_valid,
  output logic [IDW-1:0] o_gnt_id
);

  int w_idx;

  // Scan from the farthest offset down so the nearest pending channel wins.
  always_comb begin
    o_gnt_valid = 1'b0;
    o_gnt_id    = '0;
    w_idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = (int'(i_ptr) + k) % N;
      if (i_pending[w_idx]) begin
        o_gnt_valid = 1'b1;
        o_gnt_id    = IDW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/shared_subtract_scheduler.sv
// Shares one W-bit subtractor among N toggle-handshake requesters, round-robin; result SUB_DELAY edges after capture,
// held until the consumer acks (one transaction in flight). REQ_SYNC_EN adds 2-flop synchronizers on req/out_ack.
module shared_subtract_scheduler
  import shared_sub_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int W         = DEF_W,
  parameter int SUB_DELAY = DEF_SUB_DELAY
) (
  input logic                    clk,
  input logic                    reset,
  shared_subtract_scheduler_if.slave bus
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = (SUB_DELAY > 1) ? $clog2(SUB_DELAY) : 1;

  logic [N-1:0]   w_req;
  logic           w_out_ack;
  logic [N-1:0]   w_pending;
  logic           w_gnt_valid;
  logic [IDW-1:0] w_gnt_id;

  sched_state_t   r_state;
  logic [CW-1:0]  r_cnt;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [N-1:0]   r_ack;
  logic           r_out_req;
  logic [W-1:0]   r_diff;
  logic           r_borrow;
  logic [IDW-1:0] r_out_id;

`ifdef REQ_SYNC_EN
  logic [N-1:0] r_req_s1;
  logic [N-1:0] r_req_s2;
  logic         r_oack_s1;
  logic         r_oack_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_s1  <= '0;
      r_req_s2  <= '0;
      r_oack_s1 <= 1'b0;
      r_oack_s2 <= 1'b0;
    end else begin
      r_req_s1  <= bus.req;
      r_req_s2  <= r_req_s1;
      r_oack_s1 <= bus.out_ack;
      r_oack_s2 <= r_oack_s1;
    end
  end

  assign w_req     = r_req_s2;
  assign w_out_ack = r_oack_s2;
`else
  assign w_req     = bus.req;
  assign w_out_ack = bus.out_ack;
`endif

  assign w_pending = w_req ^ r_ack;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_pick (
    .i_pending   (w_pending),
    .i_ptr       (r_ptr),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_id      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_ack     <= '0;
      r_out_req <= 1'b0;
      r_diff    <= '0;
      r_borrow  <= 1'b0;
      r_out_id  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_a     <= bus.a_data[int'(w_gnt_id) * W +: W];
            r_b     <= bus.b_data[int'(w_gnt_id) * W +: W];
            r_id    <= w_gnt_id;
            r_cnt   <= CW'(SUB_DELAY - 1);
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            r_diff    <= r_a - r_b;
            r_borrow  <= sub_borrow(32'(r_a), 32'(r_b));
            r_out_id  <= r_id;
            r_out_req <= ~r_out_req;
            r_state   <= WAIT_ACK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        WAIT_ACK: begin
          // The requester is only released once the consumer has taken the result.
          if (w_out_ack == r_out_req) begin
            r_ack[r_id] <= ~r_ack[r_id];
            r_ptr       <= (r_id == IDW'(N - 1)) ? '0 : r_id + 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ack        = r_ack;
  assign bus.out_req    = r_out_req;
  assign bus.out_diff   = r_diff;
  assign bus.out_borrow = r_borrow;
  assign bus.out_id     = r_out_id;
  assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_shared_subtract_scheduler.sv
// Directed plus randomized bench for shared_subtract_scheduler against a
// round-robin transaction-level reference model.
module tb_shared_subtract_scheduler;
  import shared_sub_pkg::*;

  localparam int N         = DEF_N;
  localparam int W         = DEF_W;
  localparam int SUB_DELAY = 2;
`ifdef REQ_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shared_subtract_scheduler_if #(.N(N), .W(W)) bif ();

  shared_subtract_scheduler #(
    .N         (N),
    .W         (W),
    .SUB_DELAY (SUB_DELAY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  int checks = 0;
  int errors = 0;

  int         mdl_ptr;
  bit         mdl_pend [N];
  logic [7:0] mdl_a    [N];
  logic [7:0] mdl_b    [N];
  int         last_wait;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int next_grant();
    for (int k = 0; k < N; k++) begin
      if (mdl_pend[(mdl_ptr + k) % N]) return (mdl_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < N; i++) if (mdl_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_ops(input int ch, input logic [7:0] a, input logic [7:0] b);
    bif.a_data[ch*W +: W] = a;
    bif.b_data[ch*W +: W] = b;
    mdl_a[ch] = a;
    mdl_b[ch] = b;
  endtask

  task automatic request(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        chk("req_not_pending_before_toggle", 32'(bif.ack[i]), 32'(bif.req[i]));
        mdl_pend[i] = 1'b1;
      end
    end
    bif.req = bif.req ^ mask;
  endtask

  task automatic check_reset_outs(input string where);
    chk({where, "_ack"},    32'(bif.ack),        32'd0);
    chk({where, "_outreq"}, 32'(bif.out_req),    32'd0);
    chk({where, "_busy"},   32'(bif.busy),       32'd0);
    chk({where, "_diff"},   32'(bif.out_diff),   32'd0);
    chk({where, "_borrow"}, 32'(bif.out_borrow), 32'd0);
    chk({where, "_id"},     32'(bif.out_id),     32'd0);
  endtask

  task automatic clear_model();
    mdl_ptr = 0;
    for (int i = 0; i < N; i++) mdl_pend[i] = 1'b0;
  endtask

  // Requesters and consumer are reset together with the DUT.
  task automatic do_reset(input int cycles, input logic [N-1:0] req_during);
    reset       = 1'b1;
    bif.req     = req_during;
    bif.out_ack = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      check_reset_outs("reset");
    end
    reset = 1'b0;
    clear_model();
    for (int i = 0; i < N; i++) mdl_pend[i] = req_during[i];
  endtask

  task automatic serve(input int ack_delay);
    int         exp_id;
    int         cyc;
    logic       prev;
    logic       exp_rq;
    logic [7:0] exp_d;
    logic       exp_bw;
    logic [N-1:0] ack0;
    logic [N-1:0] exp_ack;
    exp_id = next_grant();
    prev   = bif.out_req;
    exp_rq = ~prev;
    cyc    = 0;
    while (bif.out_req === prev && cyc < 64) begin
      tick();
      cyc++;
    end
    last_wait = cyc;
    chk("out_req_toggle", 32'(bif.out_req), 32'(exp_rq));
    exp_d  = mdl_a[exp_id] - mdl_b[exp_id];
    exp_bw = (mdl_a[exp_id] < mdl_b[exp_id]);
    chk("out_id",     32'(bif.out_id),     32'(exp_id));
    chk("out_diff",   32'(bif.out_diff),   32'(exp_d));
    chk("out_borrow", 32'(bif.out_borrow), 32'(exp_bw));
    ack0 = bif.ack;
    for (int d = 0; d < ack_delay; d++) begin
      tick();
      chk("bp_id",   32'(bif.out_id),   32'(exp_id));
      chk("bp_diff", 32'(bif.out_diff), 32'(exp_d));
      chk("bp_ack",  32'(bif.ack),      32'(ack0));
      chk("bp_busy", 32'(bif.busy),     32'd1);
    end
    bif.out_ack = bif.out_req;
    cyc = 0;
    while (bif.ack === ack0 && cyc < 16) begin
      tick();
      cyc++;
    end
    chk("ack_latency", 32'(cyc), 32'(1 + SYNC));
    exp_ack = ack0;
    exp_ack[exp_id] = ~exp_ack[exp_id];
    chk("ack_vec", 32'(bif.ack), 32'(exp_ack));
    mdl_pend[exp_id] = 1'b0;
    mdl_ptr = (exp_id + 1) % N;
  endtask

  task automatic wait_busy(output int cyc);
    cyc = 0;
    while (bif.busy !== 1'b1 && cyc < 16) begin
      tick();
      cyc++;
    end
  endtask

  task automatic idle_after_reset(input string where);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk({where, "_no_stale_ack"}, 32'(bif.ack),  32'd0);
      chk({where, "_idle"},         32'(bif.busy), 32'd0);
    end
  endtask

  initial begin
    int cyc;
    logic [N-1:0] mask;
    logic prev;
    logic exp_rq;

    reset      = 1'b1;
    bif.req    = '0;
    bif.a_data = '0;
    bif.b_data = '0;
    bif.out_ack = 1'b0;
    clear_model();

    // 1: reset with all requests high, then ch0 first
    for (int i = 0; i < N; i++) set_ops(i, 8'($urandom), 8'($urandom));
    do_reset(3, 4'b1111);
    for (int i = 0; i < N; i++) begin
      serve(0);
      chk("s1_order", 32'(bif.out_id), 32'(i));
    end

    // 2: single request on ch2
    set_ops(2, 8'd50, 8'd20);
    request(4'b0100);
    wait_busy(cyc);
    chk("s2_capture_latency", 32'(cyc), 32'(1 + SYNC));
    serve(0);
    chk("s2_result_latency", 32'(last_wait), 32'(SUB_DELAY));
    chk("s2_diff",   32'(bif.out_diff),   32'd30);
    chk("s2_borrow", 32'(bif.out_borrow), 32'd0);
    chk("s2_id",     32'(bif.out_id),     32'd2);

    // 3: borrow
    set_ops(1, 8'd5, 8'd9);
    request(4'b0010);
    serve(0);
    chk("s3_diff",   32'(bif.out_diff),   32'd252);
    chk("s3_borrow", 32'(bif.out_borrow), 32'd1);

    // 4: contention from a fresh pointer
    do_reset(1, 4'b0000);
    for (int i = 0; i < N; i++) set_ops(i, 8'($urandom), 8'($urandom));
    request(4'b1111);
    for (int i = 0; i < N; i++) begin
      serve(0);
      chk("s4_order", 32'(bif.out_id), 32'(i));
    end
    set_ops(0, 8'd200, 8'd1);
    set_ops(3, 8'd0, 8'd255);
    request(4'b1001);
    serve(0);
    chk("s4_second_first", 32'(bif.out_id), 32'd0);
    serve(0);
    chk("s4_second_next", 32'(bif.out_id), 32'd3);

    // 5: back-pressure with another channel waiting
    set_ops(1, 8'd77, 8'd33);
    set_ops(2, 8'd10, 8'd11);
    request(4'b0110);
    serve(20);
    serve(0);

    // 6a: reset while BUSY
    set_ops(1, 8'd9, 8'd4);
    request(4'b0010);
    wait_busy(cyc);
    chk("s6_busy_reached", 32'(bif.busy), 32'd1);
    reset   = 1'b1;
    bif.req = '0;
    bif.out_ack = 1'b0;
    tick();
    check_reset_outs("s6_busy");
    reset = 1'b0;
    clear_model();
    idle_after_reset("s6_busy");

    // 6b: reset while WAIT_ACK
    set_ops(3, 8'd100, 8'd1);
    request(4'b1000);
    prev   = bif.out_req;
    exp_rq = ~prev;
    cyc    = 0;
    while (bif.out_req === prev && cyc < 64) begin
      tick();
      cyc++;
    end
    chk("s6_wait_ack_reached", 32'(bif.out_req), 32'(exp_rq));
    reset   = 1'b1;
    bif.req = '0;
    bif.out_ack = 1'b0;
    tick();
    check_reset_outs("s6_wait");
    reset = 1'b0;
    clear_model();
    idle_after_reset("s6_wait");

    // randomized rounds against the reference model
    for (int r = 0; r < 25; r++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        if (mask[i]) set_ops(i, 8'($urandom), 8'($urandom));
      end
      request(mask);
      while (any_pending()) serve($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
